// File: rtl/cdc_tx_queue.sv
// cdc_tx_queue: transmit-domain FIFO that feeds a CDC handshaker one word at a time.
// Build macro TXQ_DROP_COUNT_EN enables the saturating dropped-write counter on DropCount.
module cdc_tx_queue #(
  parameter int WID_DATA   = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [WID_DATA-1:0]   WrData,
  input  logic                  WrEnable,
  output logic                  Full,
  output logic                  Empty,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow,
  input  logic                  OvfClear,
  output logic [WID_DATA-1:0]   HsData,
  output logic                  HsStart,
  input  logic                  HsBusy,
  output logic [7:0]            DropCount,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_ACCEPT = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WID_DATA-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  start_q, start_d;
  logic [WID_DATA-1:0]   data_q, data_d;
  logic                  full, empty, wr_acc, drop, pop;

  // Full/empty come from the count alone, judged on pre-edge state.
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign wr_acc = WrEnable && !full;
  assign drop   = WrEnable && full;
  assign pop    = (state_q == S_IDLE) && !empty && !HsBusy;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ACCEPT;
      S_ACCEPT: begin
        // No busy response means the start was missed: pulse again with the same word.
        if (HsBusy) begin
          state_d = S_DRAIN;
        end else begin
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (!HsBusy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (OvfClear) ovf_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  // Storage is deliberately left out of reset; count and pointers define validity.
  always_ff @(posedge Clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= WrData;
  end

`ifdef TXQ_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (OvfClear) drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (OvfClear) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign DropCount = drop_cnt_q;
`else
  assign DropCount = 8'd0;
`endif

  assign Full      = full;
  assign Empty     = empty;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign HsData    = data_q;
  assign HsStart   = start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cdc_tx_queue.sv
// Bench for cdc_tx_queue: random and directed writes against a queue-based reference
// model, with a behavioural handshaker whose busy response can be delayed or withheld.
module tb_cdc_tx_queue;

  localparam int DEPTH = 4;
`ifdef TXQ_DROP_COUNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  // Clock / reset
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] WrData = '0;
  logic       WrEnable = 1'b0;
  logic       OvfClear = 1'b0;
  logic       HsBusy = 1'b0;
  logic       Full, Empty, Overflow, HsStart;
  logic [2:0] Count;
  logic [7:0] HsData, DropCount;
  logic [1:0] dbg_state;

  always #5 Clock = ~Clock;

  cdc_tx_queue #(.WID_DATA(8), .DEPTH_LOG2(2)) dut (
    .Clock(Clock), .Reset(Reset), .WrData(WrData), .WrEnable(WrEnable),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
    .OvfClear(OvfClear), .HsData(HsData), .HsStart(HsStart), .HsBusy(HsBusy),
    .DropCount(DropCount), .dbg_state(dbg_state)
  );

  // Reference model state
  logic [7:0] exp_q[$];
  int         model_count = 0;
  bit         model_ovf = 0;
  int         model_drop = 0;
  logic [7:0] model_hs_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_accepts = 0;

  // Handshaker model controls
  bit force_busy = 0;
  bit random_mode = 0;
  int fixed_len = 1;
  bit reject_next = 0;
  bit hs_go = 0;
  bit hs_arm = 0;
  int hs_len = 1;
  int busy_left = 0;

  // Monitor state
  int cyc = 0;
  bit prev_start = 0;
  bit retry_pending = 0;
  int reject_cyc = 0;
  bit accept = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  // Driver: called at posedge+2; inputs are sampled at the following edge.
  task automatic drive(input bit we, input logic [7:0] d, input bit clr);
    bit is_drop;
    WrEnable = we;
    WrData   = d;
    OvfClear = clr;
    is_drop  = we && (model_count >= DEPTH);
    if (we && !is_drop) begin
      exp_q.push_back(d);
      model_count++;
    end
    if (is_drop) model_ovf = 1;
    else if (clr) model_ovf = 0;
    if (DROP_EN != 0) begin
      if (is_drop) model_drop = clr ? 1 : ((model_drop >= 255) ? 255 : model_drop + 1);
      else if (clr) model_drop = 0;
    end
    @(posedge Clock);
    #2;
    WrEnable = 1'b0;
    OvfClear = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || HsBusy || hs_arm || hs_go || retry_pending) && n < 300) begin
      @(posedge Clock);
      #2;
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
    repeat (3) begin
      @(posedge Clock);
      #2;
    end
  endtask

  // Handshaker: busy rises the cycle after it registers a start, then holds hs_len cycles.
  initial begin
    forever begin
      @(posedge Clock);
      #3;
      if (!Reset) begin
        hs_arm = 0;
        busy_left = 0;
      end else begin
        if (busy_left > 0) busy_left--;
        if (hs_arm) begin
          busy_left = hs_len;
          hs_arm = 0;
        end
        if (hs_go) begin
          hs_arm = 1;
          hs_go = 0;
        end
      end
      HsBusy = force_busy || (busy_left > 0);
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (!Reset) begin
        prev_start = 0;
        retry_pending = 0;
        hs_go = 0;
        continue;
      end
      cyc++;
      if (HsStart) begin
        chk("start_back_to_back", prev_start, 0);
        chk("start_while_busy", HsBusy, 0);
        if (exp_q.size() == 0) begin
          fail_now("start_unexpected");
        end else begin
          chk("hs_data", HsData, exp_q[0]);
          if (retry_pending) begin
            chk("retry_gap", cyc - reject_cyc, 2);
          end else begin
            model_count--;
            model_hs_data = exp_q[0];
          end
          accept = 1;
          if (reject_next) begin
            accept = 0;
            reject_next = 0;
          end else if (random_mode) begin
            accept = ($urandom_range(0, 5) != 0);
          end
          if (accept) begin
            void'(exp_q.pop_front());
            retry_pending = 0;
            hs_len = random_mode ? $urandom_range(1, 6) : fixed_len;
            hs_go = 1;
            n_accepts++;
          end else begin
            retry_pending = 1;
            reject_cyc = cyc;
          end
        end
      end else if (retry_pending && (cyc - reject_cyc >= 2)) begin
        fail_now("retry_missing");
        retry_pending = 0;
      end
      chk("count", Count, model_count);
      chk("full", Full, model_count == DEPTH);
      chk("empty", Empty, model_count == 0);
      chk("overflow", Overflow, model_ovf);
      chk("drop_count", DropCount, model_drop);
      chk("hs_data_hold", HsData, model_hs_data);
      prev_start = HsStart;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    int acc0;
    #1;
    chk("rst_count", Count, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_start", HsStart, 0);
    chk("rst_data", HsData, 0);
    chk("rst_drop", DropCount, 0);
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b1;

    // Single word latency
    drive(1, 8'hA5, 0);
    @(posedge Clock);
    #1;
    chk("lat_start", HsStart, 1);
    chk("lat_data", HsData, 8'hA5);
    #1;
    wait_idle();
    chk("single_count", Count, 0);
    chk("single_empty", Empty, 1);

    // Burst against a slow handshaker
    fixed_len = 6;
    acc0 = n_accepts;
    for (int i = 1; i <= 4; i++) drive(1, 8'(i), 0);
    wait_idle();
    chk("burst_accepts", n_accepts - acc0, 4);

    // Retry after a missed start
    fixed_len = 1;
    reject_next = 1;
    drive(1, 8'h3C, 0);
    @(posedge Clock);
    #1;
    chk("retry_first_start", HsStart, 1);
    chk("retry_first_data", HsData, 8'h3C);
    @(posedge Clock);
    #1;
    chk("retry_gap_low", HsStart, 0);
    @(posedge Clock);
    #1;
    chk("retry_second_start", HsStart, 1);
    chk("retry_second_data", HsData, 8'h3C);
    chk("retry_count", Count, 0);
    #1;
    wait_idle();

    // Overflow, clear, collision, saturation
    force_busy = 1;
    for (int i = 0; i < 5; i++) drive(1, 8'h10 + 8'(i), 0);
    chk("ovf_full", Full, 1);
    chk("ovf_flag", Overflow, 1);
    chk("ovf_drop", DropCount, DROP_EN);
    drive(0, 8'h00, 1);
    chk("ovf_cleared", Overflow, 0);
    chk("ovf_count_kept", Count, 4);
    drive(1, 8'hEE, 1);
    chk("ovf_collision_flag", Overflow, 1);
    chk("ovf_collision_drop", DropCount, DROP_EN);
    for (int i = 0; i < 260; i++) drive(1, 8'($urandom), 0);
    chk("drop_saturate", DropCount, DROP_EN * 255);
    drive(0, 8'h00, 1);
    chk("drop_cleared", DropCount, 0);
    force_busy = 0;
    wait_idle();

    // Write on the pop edge
    force_busy = 1;
    drive(1, 8'h20, 0);
    drive(1, 8'h21, 0);
    chk("simul_pre_count", Count, 2);
    force_busy = 0;
    drive(1, 8'h77, 0);
    chk("simul_count", Count, 2);
    wait_idle();

    // Randomized traffic
    random_mode = 1;
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 19) == 0);
    wait_idle();
    random_mode = 0;
    drive(0, 8'h00, 1);

    // Asynchronous reset during DRAIN with three words queued
    force_busy = 1;
    for (int i = 0; i < 5; i++) drive(1, 8'h30 + 8'(i), 0);
    fixed_len = 8;
    force_busy = 0;
    repeat (4) drive(0, 8'h00, 0);
    chk("pre_reset_count", Count, 3);
    chk("pre_reset_ovf", Overflow, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_start", HsStart, 0);
    chk("async_count", Count, 0);
    chk("async_empty", Empty, 1);
    chk("async_full", Full, 0);
    chk("async_overflow", Overflow, 0);
    chk("async_data", HsData, 0);
    chk("async_drop", DropCount, 0);
    exp_q.delete();
    model_count = 0;
    model_ovf = 0;
    model_drop = 0;
    model_hs_data = '0;
    repeat (2) @(posedge Clock);
    #2;
    Reset = 1'b1;

    // Resume after reset
    fixed_len = 1;
    drive(1, 8'h5A, 0);
    drive(1, 8'hC3, 0);
    wait_idle();
    chk("resume_count", Count, 0);
    chk("resume_empty", Empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
